// File: rtl/mdi_register_bank.sv
// Bank of DEPTH measure-once MDI cells: each read collapses its cell and releases
// the stored value only when the peer basis matches; a fuse kill disables the whole bank.
module mdi_register_bank #(
    parameter int WIDTH   = 8,
    parameter int BASIS_W = 2,
    parameter int DEPTH   = 16,
    parameter int WIPE    = 1,
    parameter int REARM   = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [AW-1:0]      init_addr,
    input  logic [WIDTH-1:0]   value_in,
    input  logic [BASIS_W-1:0] basis_in,
    output logic               init_err,
    input  logic               rd_req,
    input  logic [AW-1:0]      rd_addr,
    input  logic [BASIS_W-1:0] peer_basis,
    output logic [BASIS_W-1:0] basis_q,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_match,
    output logic               rd_err,
    output logic               pad_enable,
    output logic               fuse_fire,
    input  logic               fuse_blow,
    output logic               killed,
    output logic [AW:0]        live_count
);

    typedef enum logic [1:0] {
        CELL_EMPTY,
        CELL_ARMED,
        CELL_COLLAPSED
    } cell_state_t;

    cell_state_t        state [DEPTH];
    logic [WIDTH-1:0]   value [DEPTH];
    logic [BASIS_W-1:0] basis [DEPTH];
    logic [15:0]        lfsr;

    logic        kill_now;
    logic        rd_armed;
    logic        rd_hit;
    logic        init_ok;
    logic        init_inc;
    logic        lfsr_fb;
    logic [AW:0] live_next;

    always_comb begin
        // A fuse_blow on this edge already counts as killed for reads and inits.
        kill_now  = killed | fuse_blow;
        rd_armed  = rd_req & ~kill_now & (state[rd_addr] == CELL_ARMED);
        rd_hit    = rd_armed & (peer_basis == basis[rd_addr]);
        init_ok   = init & ~kill_now
                  & ~(rd_req & (rd_addr == init_addr))
                  & ((state[init_addr] != CELL_COLLAPSED) | (REARM != 0));
        init_inc  = init_ok & (state[init_addr] != CELL_ARMED);
        live_next = live_count;
        if (init_inc && !rd_armed) begin
            live_next = live_count + 1'b1;
        end else if (rd_armed && !init_inc) begin
            live_next = live_count - 1'b1;
        end
        lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        basis_q   = (killed || state[rd_addr] == CELL_EMPTY) ? '0 : basis[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                state[i] <= CELL_EMPTY;
                value[i] <= '0;
                basis[i] <= '0;
            end
            lfsr       <= 16'hACE1;
            killed     <= 1'b0;
            live_count <= '0;
            fuse_fire  <= 1'b0;
            init_err   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_match   <= 1'b0;
            pad_enable <= 1'b0;
            rd_data    <= '0;
        end else begin
            lfsr       <= {lfsr_fb, lfsr[15:1]};
            killed     <= kill_now;
            live_count <= live_next;
            fuse_fire  <= rd_armed;
            init_err   <= init & ~init_ok;
            rd_valid   <= rd_req;
            rd_err     <= rd_req & ~rd_armed;
            rd_match   <= rd_hit;
            pad_enable <= rd_hit;
            rd_data    <= rd_hit ? value[rd_addr] : (rd_req ? lfsr[WIDTH-1:0] : '0);
            if (rd_armed) begin
                state[rd_addr] <= CELL_COLLAPSED;
                if (WIPE != 0) begin
                    value[rd_addr] <= lfsr[WIDTH-1:0];
                end
            end
            // init_ok excludes the read address, so these writes never target the same cell.
            if (init_ok) begin
                state[init_addr] <= CELL_ARMED;
                value[init_addr] <= value_in;
                basis[init_addr] <= basis_in;
            end
        end
    end

endmodule

// File: doc/mdi_register_bank.md
# mdi_register_bank

Parametrised bank of DEPTH measure-once MDI cells, each holding a WIDTH-bit value and a BASIS_W-bit prepared basis, replacing the single-cell MDI register in the QKD datapath. A read consumes the addressed cell on the same edge regardless of basis outcome. The stored value is released only when the matcher-supplied peer basis equals the cell's basis. Adds addressing, a registered read handshake, optional wipe-on-collapse, a live-cell counter and a bank-wide fuse kill.

## Interface
- WIDTH, 8: stored value width, 1..16.
- BASIS_W, 2: basis width.
- DEPTH, 16: number of cells, power of two, ≥2; AW = log2(DEPTH).
- WIPE, 1: 1 = overwrite cell value with LFSR on collapse.
- REARM, 0: 1 = init may re-provision a COLLAPSED cell.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- init  in  1  provision strobe.
- init_addr  in  AW  cell to provision.
- value_in  in  WIDTH  value to store.
- basis_in  in  BASIS_W  prepared basis.
- init_err  out  1  1-cycle pulse, init rejected.
- rd_req  in  1  read strobe, one cycle.
- rd_addr  in  AW  cell to read.
- peer_basis  in  BASIS_W  peer basis from matcher, sampled with rd_req.
- basis_q  out  BASIS_W  basis of cell at rd_addr, combinational, for matcher.
- rd_valid  out  1  1-cycle response pulse.
- rd_data  out  WIDTH  response data.
- rd_match  out  1  bases matched, data genuine.
- rd_err  out  1  read hit non-ARMED cell or killed bank.
- pad_enable  out  1  physical OE, high only with rd_valid & rd_match.
- fuse_fire  out  1  1-cycle pulse per collapse.
- fuse_blow  in  1  external bank kill request.
- killed  out  1  sticky bank kill.
- live_count  out  AW+1  number of ARMED cells.

## Operation
- Per-cell state: EMPTY → ARMED (via init) → COLLAPSED (via read). COLLAPSED → ARMED only when REARM=1. Reset puts every cell in EMPTY.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every cycle. Obfuscation data is lfsr[WIDTH-1:0].
- Read of an ARMED cell with killed=0, on the edge:
  - cell → COLLAPSED; fuse_fire=1; live_count decrements.
  - If WIPE=1, the cell value is overwritten with lfsr.
  - Response registers load: rd_valid=1, rd_match=(peer_basis==cell basis).
  - rd_data = stored value if matched, else lfsr.
  - pad_enable = rd_match.
- Read of an EMPTY or COLLAPSED cell, or while killed: rd_valid=1, rd_err=1, rd_match=0, rd_data=lfsr, pad_enable=0. No state change, no fuse_fire.
- Init of EMPTY cell (or COLLAPSED with REARM=1): store value and basis, cell → ARMED, live_count increments.
- Init of an ARMED cell overwrites value and basis; live_count is unchanged.
- Init rejected, with init_err pulse and no state change, when:
  - the cell is COLLAPSED and REARM=0;
  - killed=1;
  - the init collides with a read to the same address.
- Simultaneous init and read to different addresses: both execute. live_count nets the ±1 changes.
- Read and init on the same address: the read sees pre-edge state; the init is rejected.
- fuse_blow: killed←1 permanently (until reset). A read on the same edge is treated as killed: rd_err=1, no collapse. Killed forces pad_enable=0.
- live_count saturates at DEPTH and 0 by construction; it never wraps.

## Timing
- Reset values: rd_valid, rd_data, rd_match, rd_err, pad_enable, fuse_fire, init_err, killed all 0; live_count 0; lfsr seed.
- Read latency is 1: request at edge N gives the response outputs valid during cycle N+1, for exactly one cycle.
- Back-to-back reads, one per cycle, are supported.
- Reset asserted mid-operation clears all state immediately (asynchronous), including any pending response.
- basis_q is combinational from rd_addr. It reads 0 for EMPTY cells and for all cells when killed.

## Test plan
- Arm cell 3 with 8'h5A, basis 2'b01 → live_count=1. Read 3 with peer 2'b01 → next cycle rd_valid=1, rd_match=1, rd_data=8'h5A, pad_enable=1, fuse_fire=1, live_count=0.
- Arm cell 5 with basis 2'b10. Read with peer 2'b11 → rd_match=0, rd_data=lfsr, pad_enable=0, fuse_fire=1. Re-read 5 → rd_err=1, no fuse_fire.
- REARM=0: init cell 5 after collapse → init_err=1, cell stays COLLAPSED. REARM=1: the same init → ARMED, live_count+1.
- Same-cycle init and read to cell 7 (ARMED) → read returns old value, init_err=1. Different addresses in the same cycle → both apply, live_count unchanged.
- fuse_blow in the same cycle as a read of an ARMED cell → rd_err=1, no fuse_fire, killed=1. All later reads return rd_err; inits return init_err.
- Assert reset mid-stream with rd_valid pending → all outputs 0 immediately; every cell EMPTY afterwards.
